// File: rtl/bcd_down_timer.sv
// bcd_down_timer: loadable multi-digit BCD countdown timer with terminal pulse and optional auto-reload
module bcd_down_timer #(
  parameter int DIGITS      = 4,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  tick,
  output logic [4*DIGITS-1:0]   out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  localparam int W = 4 * DIGITS;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t         state, nxt;
  logic [W-1:0]   preset, dec;
  logic           valid, borrow, term;
  // A preset is accepted only if every digit is a legal BCD code
  always_comb begin
    valid = 1'b1;
    for (int i = 0; i < DIGITS; i++) valid = valid & (load_val[4*i+:4] <= 4'd9);
  end
  // Ripple-borrow BCD decrement: a zero digit wraps to 9 and borrows from the next digit
  always_comb begin
    dec    = out;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      dec[4*i+:4] = borrow ? (out[4*i+:4] == 4'd0 ? 4'd9 : out[4*i+:4] - 4'd1) : out[4*i+:4];
      borrow      = borrow & (out[4*i+:4] == 4'd0);
    end
  end
  assign term = (state == S_RUN) && !load && !stop && tick && (out == W'(1));
  // State register
  always_ff @(posedge clk or negedge res) begin
    if (!res) state <= S_IDLE;
    else      state <= nxt;
  end
  // Next state: load beats stop beats start; an invalid load freezes the cycle
  always_comb begin
    nxt = load ? (valid ? S_IDLE : state) :
          (state == S_RUN) ? (stop ? S_IDLE :
                              term ? (AUTO_RELOAD ? (preset != '0 ? S_RUN : S_IDLE) : S_DONE) :
                              S_RUN) :
          (state == S_DONE) ? S_IDLE :
          (start && out != '0) ? S_RUN : S_IDLE;
  end
  // Outputs decoded from state
  always_comb begin
    busy = (state == S_RUN);
  end
  // Count, preset, error flag and registered terminal pulse
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      out    <= '0;
      preset <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= term;
      if (load) begin
        err <= !valid;
        if (valid) begin
          preset <= load_val;
          out    <= load_val;
        end
      end else if (state == S_RUN && !stop && tick) begin
        out <= (term && AUTO_RELOAD) ? preset : dec;
      end
    end
  end
endmodule

// File: tb/tb_bcd_down_timer.sv
// tb_bcd_down_timer: directed vector table plus hand sequences for both reload modes
module tb_bcd_down_timer;
  logic        clk = 1'b0, res = 1'b0, load = 1'b0, start = 1'b0, stop = 1'b0, tick = 1'b0;
  logic [15:0] load_val = '0;
  logic [15:0] out0, out1;
  logic        busy0, busy1, done0, done1, err0, err1;
  int          tests = 0, fails = 0;

  always #5 clk = ~clk;

  bcd_down_timer #(.DIGITS(4), .AUTO_RELOAD(1'b0)) u0 (
    .clk(clk), .res(res), .load(load), .load_val(load_val), .start(start), .stop(stop),
    .tick(tick), .out(out0), .busy(busy0), .done(done0), .err(err0));
  bcd_down_timer #(.DIGITS(4), .AUTO_RELOAD(1'b1)) u1 (
    .clk(clk), .res(res), .load(load), .load_val(load_val), .start(start), .stop(stop),
    .tick(tick), .out(out1), .busy(busy1), .done(done1), .err(err1));

  typedef struct {
    logic ar; logic ld; logic [15:0] lv; logic st; logic sp; logic tk;
    logic [15:0] eo; logic eb; logic ed; logic ee;
  } vec_t;
  vec_t v[$];

  function automatic vec_t mk(input logic ar, ld, input logic [15:0] lv, input logic st, sp, tk,
                              input logic [15:0] eo, input logic eb, ed, ee);
    mk = '{ar, ld, lv, st, sp, tk, eo, eb, ed, ee};
  endfunction

  function automatic logic [15:0] bcd(input int n);
    bcd = '0;
    for (int d = 0; d < 4; d++) begin
      bcd[4*d+:4] = 4'(n % 10);
      n = n / 10;
    end
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic [15:0] lv, input logic st, sp, tk);
    load = ld; load_val = lv; start = st; stop = sp; tick = tk;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state while res is held low
    #2;
    chk("reset out0", out0, 16'h0000);
    chk("reset busy0", {15'd0, busy0}, 16'd0);
    chk("reset done0", {15'd0, done0}, 16'd0);
    chk("reset err0", {15'd0, err0}, 16'd0);
    chk("reset out1", out1, 16'h0000);
    @(negedge clk);
    res = 1'b1;

    // invalid load handling
    v.push_back(mk(0, 1, 16'h0050, 0, 0, 0, 16'h0050, 0, 0, 0));
    v.push_back(mk(0, 1, 16'h12A4, 0, 0, 0, 16'h0050, 0, 0, 1));
    v.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 16'h0050, 0, 0, 1));
    v.push_back(mk(0, 1, 16'h0003, 0, 0, 0, 16'h0003, 0, 0, 0));
    // pause / resume and tick gating
    v.push_back(mk(0, 1, 16'h0010, 0, 0, 0, 16'h0010, 0, 0, 0));
    v.push_back(mk(0, 0, 16'h0000, 1, 0, 0, 16'h0010, 1, 0, 0));
    v.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 16'h0009, 1, 0, 0));
    v.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 16'h0008, 1, 0, 0));
    v.push_back(mk(0, 0, 16'h0000, 0, 1, 0, 16'h0008, 0, 0, 0));
    for (int i = 0; i < 5; i++) v.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 16'h0008, 0, 0, 0));
    v.push_back(mk(0, 0, 16'h0000, 1, 0, 0, 16'h0008, 1, 0, 0));
    for (int n = 7; n >= 1; n--) v.push_back(mk(0, 0, 16'h0000, 0, 0, 1, bcd(n), 1, 0, 0));
    v.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 16'h0000, 0, 1, 0));
    v.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0));
    v.push_back(mk(0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 0));
    // command priority
    v.push_back(mk(0, 1, 16'h0020, 0, 0, 0, 16'h0020, 0, 0, 0));
    v.push_back(mk(0, 0, 16'h0000, 1, 0, 0, 16'h0020, 1, 0, 0));
    v.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 16'h0019, 1, 0, 0));
    v.push_back(mk(0, 1, 16'h0005, 1, 1, 1, 16'h0005, 0, 0, 0));
    v.push_back(mk(0, 0, 16'h0000, 1, 0, 0, 16'h0005, 1, 0, 0));
    v.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 16'h0004, 1, 0, 0));
    v.push_back(mk(0, 0, 16'h0000, 1, 1, 1, 16'h0004, 0, 0, 0));
    v.push_back(mk(0, 0, 16'h0000, 1, 0, 0, 16'h0004, 1, 0, 0));
    v.push_back(mk(0, 1, 16'h00F0, 0, 0, 1, 16'h0004, 1, 0, 1));
    v.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 16'h0003, 1, 0, 1));
    v.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 16'h0002, 1, 0, 1));
    // auto-reload instance
    v.push_back(mk(1, 1, 16'h0002, 0, 0, 0, 16'h0002, 0, 0, 0));
    v.push_back(mk(1, 0, 16'h0000, 1, 0, 0, 16'h0002, 1, 0, 0));
    v.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 16'h0001, 1, 0, 0));
    v.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 16'h0002, 1, 1, 0));
    v.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 16'h0001, 1, 0, 0));
    v.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 16'h0002, 1, 1, 0));
    v.push_back(mk(1, 1, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0));
    v.push_back(mk(1, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 0));

    foreach (v[k]) begin
      drive(v[k].ld, v[k].lv, v[k].st, v[k].sp, v[k].tk);
      chk($sformatf("vec%0d out", k), v[k].ar ? out1 : out0, v[k].eo);
      chk($sformatf("vec%0d busy", k), {15'd0, v[k].ar ? busy1 : busy0}, {15'd0, v[k].eb});
      chk($sformatf("vec%0d done", k), {15'd0, v[k].ar ? done1 : done0}, {15'd0, v[k].ed});
      chk($sformatf("vec%0d err", k), {15'd0, v[k].ar ? err1 : err0}, {15'd0, v[k].ee});
    end

    // borrow chain from 1000 to zero
    drive(1, 16'h1000, 0, 0, 0);
    chk("borrow load", out0, 16'h1000);
    drive(0, 16'h0000, 1, 0, 0);
    drive(0, 16'h0000, 0, 0, 1);
    chk("borrow first", out0, 16'h0999);
    for (int n = 998; n >= 0; n--) begin
      drive(0, 16'h0000, 0, 0, 1);
      chk($sformatf("borrow out %0d", n), out0, bcd(n));
      chk($sformatf("borrow done %0d", n), {15'd0, done0}, {15'd0, n == 0});
      chk($sformatf("borrow busy %0d", n), {15'd0, busy0}, {15'd0, n != 0});
    end
    drive(0, 16'h0000, 0, 0, 0);
    chk("borrow done after", {15'd0, done0}, 16'd0);
    chk("borrow busy after", {15'd0, busy0}, 16'd0);
    chk("borrow out after", out0, 16'h0000);

    // full-scale preset visits every code
    drive(1, 16'h9999, 0, 0, 0);
    drive(0, 16'h0000, 1, 0, 0);
    for (int n = 9998; n >= 0; n--) begin
      drive(0, 16'h0000, 0, 0, 1);
      chk($sformatf("full out %0d", n), out0, bcd(n));
      chk($sformatf("full done %0d", n), {15'd0, done0}, {15'd0, n == 0});
    end

    // asynchronous reset in the middle of a run, with err set beforehand
    drive(1, 16'h0012, 0, 0, 0);
    drive(0, 16'h0000, 1, 0, 0);
    drive(0, 16'h0000, 0, 0, 1);
    drive(0, 16'h0000, 0, 0, 1);
    drive(0, 16'h0000, 0, 0, 1);
    chk("midrun out", out0, 16'h0009);
    drive(1, 16'h00A0, 0, 0, 1);
    chk("midrun err", {15'd0, err0}, 16'd1);
    chk("midrun busy", {15'd0, busy0}, 16'd1);
    load = 1'b0;
    #3 res = 1'b0;
    #1;
    chk("async out0", out0, 16'h0000);
    chk("async busy0", {15'd0, busy0}, 16'd0);
    chk("async done0", {15'd0, done0}, 16'd0);
    chk("async err0", {15'd0, err0}, 16'd0);
    chk("async out1", out1, 16'h0000);
    chk("async busy1", {15'd0, busy1}, 16'd0);
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("held out0", out0, 16'h0000);
    chk("held busy0", {15'd0, busy0}, 16'd0);
    @(negedge clk);
    res = 1'b1;
    drive(0, 16'h0000, 1, 0, 1);
    chk("start at zero busy", {15'd0, busy0}, 16'd0);
    chk("start at zero done", {15'd0, done0}, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
